// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, little-endian word packing, IMEM writes.
// Optional trailer checksum is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state, state_next;
  logic [15:0] len_q;
  logic [1:0]  byte_cnt;
  logic [AW:0] word_idx;
  logic [AW:0] waddr_q;
  logic [23:0] pack_q;
  logic        accept;
  logic        last_word;
  logic [15:0] hdr_len;
  logic        in_ready_d, busy_d, done_d, err_d, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_len   = {in_data, len_q[7:0]};
  assign last_word = (16'(word_idx) == (len_q - 16'd1));
  assign waddr     = {{(32 - AW - 3){1'b0}}, waddr_q, 2'b00};

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_LO;
      LEN_LO:          if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (hdr_len == 16'd0)        state_next = DONE;
          else if (hdr_len > DEPTH16)  state_next = ERR;
          else                         state_next = DATA;
        end
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_next = (in_data == csum_q) ? DONE : ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so the registered copies line up with state.
  always_comb begin
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cpu_rst_n_d = 1'b0;
    case (state_next)
      LEN_LO, LEN_HI, DATA: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`endif
      DONE: begin
        done_d      = 1'b1;
        cpu_rst_n_d = 1'b1;
      end
      ERR:  err_d = 1'b1;
      default: cpu_rst_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cpu_rst_n <= cpu_rst_n_d;
    end
  end

  // Bytes 0..2 of a word shift into pack_q; the 4th byte completes the word straight into wdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      waddr_q  <= '0;
      pack_q   <= '0;
      we       <= 1'b0;
      wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (start && (state == IDLE || state == DONE || state == ERR)) begin
        len_q    <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q   <= '0;
`endif
      end else if (accept) begin
        case (state)
          LEN_LO: len_q[7:0]  <= in_data;
          LEN_HI: len_q[15:8] <= in_data;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            pack_q   <= {in_data, pack_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              we       <= 1'b1;
              waddr_q  <= word_idx;
              wdata    <= {in_data, pack_q};
              word_idx <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and popped by a monitor.
// Build with or without `define IMEM_LOADER_CHECKSUM_EN; trailer bytes follow that macro.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_rst_n, busy, done, err;
  logic [31:0] waddr, wdata;

  int vectors = 0;
  int miscompares = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_BUILD = 1'b1;
`else
  localparam bit CHK_BUILD = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_done;
    logic        exp_cpu;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] img[256];

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every write the DUT presents must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h expected no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write{addr,data,done,cpu_rst_n}", {30'd0, waddr, wdata, done, cpu_rst_n},
                    {30'd0, e.addr, e.data, e.exp_done, e.exp_cpu});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it; in_ready is sampled on the negedge.
  task automatic applyStimulus(input logic [7:0] b);
    int budget = 50;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) checkOutput("in_ready_timeout", 96'(in_ready), 96'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [4:0] expected);
    checkOutput(name, 96'({in_ready, busy, done, err, cpu_rst_n}), 96'(expected));
  endtask

  task automatic run_load(input int n, input int max_gap, input bit bad_trailer, input bit poke_start);
    exp_t       e;
    logic [7:0] csum = 8'h00;
    logic [7:0] b;
    logic [15:0] len16 = 16'(n);
    for (int i = 0; i < n; i++) begin
      e.addr     = 32'(i * 4);
      e.data     = img[i];
      e.exp_done = (i == n - 1) && !CHK_BUILD;
      e.exp_cpu  = (i == n - 1) && !CHK_BUILD;
      exp_q.push_back(e);
    end
    pulse_start();
    check_status("status_after_start", 5'b11000);
    applyStimulus(len16[7:0]);
    applyStimulus(len16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        csum = csum ^ b;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        if (poke_start && k == 2) pulse_start();
        applyStimulus(b);
      end
    end
    if (CHK_BUILD) applyStimulus(csum ^ {7'd0, bad_trailer});
    check_status("status_end_of_load", bad_trailer ? 5'b00010 : 5'b00101);
  endtask

  initial begin
    // Reset: everything low, cpu_rst_n rises on the first edge after release.
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 96'({in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n}), 96'd0);
    rst_n = 1'b1;
    #1 checkOutput("cpu_rst_n_before_edge", 96'(cpu_rst_n), 96'd0);
    @(posedge clk);
    #1 check_status("idle_after_reset", 5'b00001);

    // Two-word load.
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    run_load(2, 0, 1'b0, 1'b0);

    // N=257 is oversize: ERR with no writes.
    pulse_start();
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    check_status("oversize_err", 5'b00010);

    // N=0: straight to DONE with no writes.
    pulse_start();
    check_status("start_clears_err", 5'b11000);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    check_status("zero_len_done", 5'b00101);

    // Four words with random gaps and ignored start pulses.
    img[0] = 32'h03020100;
    img[1] = 32'h07060504;
    img[2] = 32'hCAFEF00D;
    img[3] = 32'h0BADC0DE;
    run_load(4, 3, 1'b0, 1'b1);

    // One-word image 11 22 33 44; checksum builds also try a bad trailer.
    img[0] = 32'h44332211;
    run_load(1, 0, 1'b0, 1'b0);
    if (CHK_BUILD) run_load(1, 0, 1'b1, 1'b0);

    // Full-capacity image: N=256 is legal, last write at 0x3FC.
    for (int i = 0; i < 256; i++) img[i] = {8'hA5, 8'(i) ^ 8'h5A, ~8'(i), 8'(i)};
    run_load(256, 0, 1'b0, 1'b0);

    // Asynchronous reset after two data bytes discards the partial word.
    pulse_start();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    @(negedge clk) rst_n = 1'b0;
    #1 checkOutput("midload_reset_outputs",
                   96'({in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n}), 96'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    run_load(2, 0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("pending_writes", 96'(exp_q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory before the core runs. It sits between a byte source (UART receiver or debug bridge) and the IMEM write port. It parses a length header, packs little-endian bytes into 32-bit words, and issues word-aligned writes. It holds the CPU in reset until the image is complete.

## Interface
Parameters:
- DEPTH, 256, IMEM capacity in words. Matches the 8-bit word index `a[9:2]`.
- AW, 8, word-index width, equal to $clog2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready
- we  out  1  one-cycle IMEM write strobe
- waddr  out  32  byte address of the write; always a multiple of 4, upper bits zero
- wdata  out  32  word to write
- cpu_rst_n  out  1  active-low reset to the core
- busy  out  1  load in progress
- done  out  1  last load finished successfully
- err  out  1  last load aborted

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK (CHK only when the checksum is compiled in), DONE, ERR.
- IDLE/DONE/ERR → LEN_LO on `start`. The same edge clears done, err, the byte counter, the word index and the checksum.
- LEN_LO: accepts byte as N[7:0]. LEN_HI: accepts byte as N[15:8].
- After LEN_HI, the next state is decided from N:
  - N==0 → DONE, with no writes.
  - N>DEPTH → ERR, with no writes.
  - Otherwise → DATA.
- DATA packs bytes little-endian: byte k of a word goes to wdata[8k+7:8k].
- On acceptance of the 4th byte of a word:
  - the write strobe fires and the word index increments;
  - after word N-1, the next state is CHK if compiled in, else DONE.
- `start` is ignored in LEN_LO, LEN_HI, DATA and CHK.
- in_ready is 1 only in LEN_LO, LEN_HI, DATA and CHK; it is 0 in IDLE, DONE and ERR. Bytes offered while in_ready=0 are not consumed.
- busy is 1 in LEN_LO, LEN_HI, DATA and CHK.
- done is 1 in DONE. err is 1 in ERR.
- cpu_rst_n is 0 while busy and in ERR; it is 1 in IDLE and DONE.
- Word index width is AW+1, so it never wraps within a legal load. waddr = {word_index, 2'b00}, zero-extended to 32 bits.

## Timing
- All outputs are registered. Reset values:
  - state=IDLE
  - in_ready=0, we=0, waddr=0, wdata=0
  - busy=0, done=0, err=0
  - cpu_rst_n=0
- cpu_rst_n rises on the first clock edge after rst_n deasserts (IDLE).
- Write latency: we=1 in the cycle after the edge that accepts the 4th byte of a word. waddr and wdata are valid in that same cycle. we is high for exactly one cycle.
- Accept rate is 1 byte per cycle; back-to-back in_valid gives one write every 4 cycles.
- Final word: we and done (or the move to CHK) appear in the same cycle. cpu_rst_n goes to 1 in that same cycle when finishing without CHK.
- in_ready drops in the cycle the state leaves DATA/CHK for DONE/ERR.
- Asynchronous rst_n mid-load aborts immediately:
  - all outputs return to their reset values;
  - a partially assembled word is discarded, not written;
  - IMEM contents already written are not restored.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The loader keeps a running XOR of all DATA bytes (header excluded).
  - After the last word it enters CHK and accepts one trailer byte.
  - If the trailer equals the XOR → DONE; otherwise → ERR.
  - The already-written words stay in IMEM. cpu_rst_n stays 0 in ERR.
  - For N==0, the CHK byte is not expected.
- Undefined:
  - No CHK state and no trailer byte; the last word → DONE directly.
  - The XOR register is not instantiated.

## Test plan
- Reset then idle: hold rst_n=0 → all outputs 0. Release → cpu_rst_n=1 next edge, in_ready=0.
- Two-word load (no checksum):
  - Stimulus: start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE.
  - Response: we at 0x0 with 0x12345678, then at 0x4 with 0xDEADBEEF.
  - done=1 and cpu_rst_n=1 in the cycle of the second we.
- Oversize/zero length:
  - Header 01 01 (N=257) → ERR, err=1, cpu_rst_n=0, no we.
  - Header 00 00 → DONE, no we, in_ready=0.
- Backpressure/gaps: toggle in_valid randomly during a 4-word load → data and addresses 0x0/0x4/0x8/0xC are unchanged. `start` pulses mid-load are ignored.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - Stimulus: 01 00 11 22 33 44, then trailer 44 (XOR of 11 22 33 44).
  - Response: DONE. With trailer 45 instead → ERR, and word 0x44332211 was still written at 0x0.
- Reset mid-load: assert rst_n=0 after 2 data bytes → no we, outputs at reset values. A fresh start plus a full image then loads correctly from address 0x0.
